// File: rtl/bus_drive_decoder_pkg.sv
// Shared bus definitions for the drive-side source decoder and the bus select encoder.
package bus_drive_decoder_pkg;

  localparam int SEL_W  = 5;
  localparam int N_SRC  = 32;
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  // General registers start at code 0; special sources occupy the top of the code space.
  localparam logic [SEL_W-1:0] SRC_REG0 = SEL_W'(0);
  localparam logic [SEL_W-1:0] SRC_PC   = SEL_W'(28);
  localparam logic [SEL_W-1:0] SRC_IMM  = SEL_W'(29);
  localparam logic [SEL_W-1:0] SRC_MEM  = SEL_W'(30);
  localparam logic [SEL_W-1:0] SRC_ALU  = SEL_W'(31);

endpackage

// File: rtl/bus_drive_decoder_if.sv
// Request/drive bundle between a bus requester (master) and the drive decoder (slave).
interface bus_drive_decoder_if #(
  parameter int SEL_W  = bus_drive_decoder_pkg::SEL_W,
  parameter int N_SRC  = bus_drive_decoder_pkg::N_SRC,
  parameter int HOLD_W = bus_drive_decoder_pkg::HOLD_W
);
  logic              req_valid;
  logic [SEL_W-1:0]  req_sel;
  logic [HOLD_W-1:0] req_hold;
  logic              req_ready;
  logic [N_SRC-1:0]  drive_en;
  logic [SEL_W-1:0]  drive_sel;
  logic              busy;
  logic              done;
  logic              sel_err;

  modport master (
    output req_valid, req_sel, req_hold,
    input  req_ready, drive_en, drive_sel, busy, done, sel_err
  );

  modport slave (
    input  req_valid, req_sel, req_hold,
    output req_ready, drive_en, drive_sel, busy, done, sel_err
  );
endinterface

// File: rtl/bus_drive_decoder_onehot_decoder.sv
// Combinational binary-to-one-hot decode with enable; the output register lives in the parent.
module onehot_decoder #(
  parameter int SEL_W = bus_drive_decoder_pkg::SEL_W,
  parameter int N_SRC = bus_drive_decoder_pkg::N_SRC
) (
  input  logic             en_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [N_SRC-1:0] onehot_o
);
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_line
    assign onehot_o[gi] = en_i && (sel_i == SEL_W'(gi));
  end
endmodule

// File: rtl/bus_drive_decoder.sv
// Sequenced source-select decoder: one registered one-hot enable per request, then a dead cycle.
// Define BUS_DRIVE_BACKTOBACK_EN to also accept requests during the turnaround cycle.
module bus_drive_decoder #(
  parameter int N_SRC  = bus_drive_decoder_pkg::N_SRC,
  parameter int SEL_W  = bus_drive_decoder_pkg::SEL_W,
  parameter int HOLD_W = bus_drive_decoder_pkg::HOLD_W
) (
  input logic               clk,
  input logic               clr,
  bus_drive_decoder_if.slave bus
);
  import bus_drive_decoder_pkg::*;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0]  drive_en_q, drive_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sel_err_q, sel_err_d;
  logic              req_ready;
  logic              accept;
  logic              in_range;
  logic              drive_on_d;
  logic [HOLD_W-1:0] hold_eff;

  assign hold_eff   = (bus.req_hold == '0) ? HOLD_W'(1) : bus.req_hold;
  assign in_range   = (32'(bus.req_sel) < 32'(N_SRC));
  assign accept     = bus.req_valid && req_ready;
  assign drive_on_d = (state_d == DRIVE);

  // The enable register is fed from next-state so the line rises in the first drive cycle.
  onehot_decoder #(
    .SEL_W(SEL_W),
    .N_SRC(N_SRC)
  ) u_onehot (
    .en_i     (drive_on_d),
    .sel_i    (sel_d),
    .onehot_o (drive_en_d)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      cnt_q      <= '0;
      drive_en_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      drive_en_q <= drive_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sel_err_q  <= sel_err_d;
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    sel_err_d = 1'b0;
    unique case (state_q)
      // TURN only sees an accept when req_ready is raised there.
      IDLE, TURN: begin
        state_d = IDLE;
        if (accept) begin
          if (in_range) begin
            state_d = DRIVE;
            sel_d   = bus.req_sel;
            cnt_d   = hold_eff;
          end else begin
            sel_err_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= HOLD_W'(1)) begin
          state_d = TURN;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == TURN);
  end

  always_comb begin : outputs
    req_ready = 1'b0;
    if (clr) begin
`ifdef BUS_DRIVE_BACKTOBACK_EN
      req_ready = (state_q == IDLE) || (state_q == TURN);
`else
      req_ready = (state_q == IDLE);
`endif
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.drive_en  = drive_en_q;
  assign bus.drive_sel = sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: doc/bus_drive_decoder.md
Name: bus_drive_decoder

Overview:
- Sequenced 5-to-32 source-select decoder for the datapath bus; the drive-side counterpart of the bus select encoder.
- Accepts a binary source code over a valid/ready handshake and drives exactly one registered one-hot output-enable line for a programmable number of cycles.
- Inserts a one-cycle dead (turnaround) cycle between bus owners so two sources never drive the bus in the same cycle.

Parameters:
- N_SRC, 32, number of bus sources / one-hot lines (at most 2**SEL_W)
- SEL_W, 5, width of the binary source code
- HOLD_W, 4, width of the drive-duration field

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_sel  input  SEL_W  binary source code to drive
- req_hold  input  HOLD_W  drive cycles; 0 is treated as 1
- req_ready  output  1  block can accept a request
- drive_en  output  N_SRC  registered one-hot bus output-enable
- drive_sel  output  SEL_W  code of the current driver (valid while busy)
- busy  output  1  DRIVE or TURN state
- done  output  1  one-cycle pulse in the turnaround cycle
- sel_err  output  1  one-cycle pulse when an out-of-range code is rejected

Behaviour:
- Reset (clr=0, asynchronous): state=IDLE; drive_en=0, drive_sel=0, busy=0, done=0, sel_err=0, hold counter=0.
  - Reset mid-DRIVE clears drive_en immediately, without waiting for a clock edge.
  - req_ready=0 while clr=0; it rises in the first cycle after release.
- All outputs are registered except req_ready, which is decoded from state.
- States: IDLE, DRIVE, TURN.
- IDLE:
  - req_ready=1.
  - Accept when req_valid and req_ready are both 1 at a clock edge (cycle T).
  - If req_sel < N_SRC: latch sel; hold = max(req_hold, 1); go to DRIVE.
  - If req_sel >= N_SRC: sel_err=1 for cycle T+1; stay in IDLE; drive_en stays 0. This case is only reachable when N_SRC < 2**SEL_W.
- DRIVE:
  - drive_en[sel]=1, all other bits 0, for cycles T+1 .. T+hold.
  - drive_sel=sel; busy=1; req_ready=0.
  - The down-counter reaches terminal count on the last drive cycle; next state is TURN.
- TURN:
  - Cycle T+hold+1: drive_en all 0, busy=1, done=1.
  - Next state IDLE; req_ready=1 again at T+hold+2.
- Latency: acceptance to first drive cycle is 1 clock. Minimum request spacing is hold+2 cycles.
- Invariants:
  - popcount(drive_en) is at most 1 in every cycle.
  - drive_en=0 in IDLE and TURN.
- req_valid held high through a busy period is not accepted until req_ready=1. Requester inputs may change freely while req_ready=0.
- hold = 2**HOLD_W - 1 (15) is the maximum; the counter never wraps.

Optional Feature:
- Macro: BUS_DRIVE_BACKTOBACK_EN.
- Defined:
  - req_ready=1 also in TURN; a request accepted in TURN moves directly to DRIVE.
  - Minimum spacing becomes hold+1 cycles.
  - The dead cycle is still guaranteed, because TURN itself has drive_en=0.
  - An out-of-range request accepted in TURN raises sel_err and returns to IDLE.
- Undefined: req_ready only in IDLE, as described above.

Decomposition:
- Shared bus package:
  - state enum (IDLE, DRIVE, TURN)
  - SEL_W and N_SRC constants
  - named source-code constants (register and special-source indices) shared with the select encoder
- One natural sub-module, onehot_decoder: a combinational SEL_W-to-N_SRC decode with an enable input, instantiated once. The output register lives in bus_drive_decoder.

Test Plan:
- Reset then single request:
  - Stimulus: release clr; req_valid=1, req_sel=5'd7, req_hold=3 at cycle 0.
  - Required: drive_en=32'h0000_0080 in cycles 1-3; cycle 4 drive_en=0 and done=1; req_ready=1 at cycle 5.
- Zero hold:
  - Stimulus: req_sel=5'd31, req_hold=0.
  - Required: drive_en=32'h8000_0000 for exactly 1 cycle, then TURN.
- Back-to-back requests:
  - Stimulus: req_valid held high with sel 2 then sel 3, hold=1 each.
  - Required: drive_en sequence 0x4, 0, (idle), 0x8. With BUS_DRIVE_BACKTOBACK_EN the idle cycle disappears: 0x4, 0, 0x8. Never two bits set in any cycle.
- Async reset mid-drive:
  - Stimulus: assert clr=0 between clock edges during DRIVE with sel 10.
  - Required: drive_en=0 and busy=0 before the next edge; state IDLE after release.
- Out of range:
  - Stimulus: build with N_SRC=24, SEL_W=5; request sel=5'd30.
  - Required: sel_err pulses 1 cycle; drive_en stays 0; req_ready stays 1.
- Max hold / random:
  - Stimulus: hold=15 with random sel over 1000 requests, with the scoreboard checking drive_en == 1<<sel.
  - Required: 15 drive cycles per request, and the one-hot invariant holds in every cycle.
